// File: rtl/gauss_pkg.sv
// Shared definitions for the 3x3 window interface: corner_type codes and the
// generator FSM encoding, also usable by computing_block.
package gauss_pkg;

   localparam logic [3:0] CT_NONE  = 4'd0;
   localparam logic [3:0] CT_TL    = 4'd1;
   localparam logic [3:0] CT_TR    = 4'd2;
   localparam logic [3:0] CT_LEFT  = 4'd3;
   localparam logic [3:0] CT_RIGHT = 4'd4;
   localparam logic [3:0] CT_BL    = 4'd5;
   localparam logic [3:0] CT_BR    = 4'd6;
   localparam logic [3:0] CT_BOT   = 4'd7;
   localparam logic [3:0] CT_FULL  = 4'd8;

   localparam int NUM_TAPS = 9;

   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_e;

   // Top row away from the corners shares the interior kernel shape.
   function automatic logic [3:0] corner_code(input logic top, input logic bot,
                                              input logic left, input logic right);
      logic [3:0] code;
      code = CT_FULL;
      if (top && left)       code = CT_TL;
      else if (top && right) code = CT_TR;
      else if (bot && left)  code = CT_BL;
      else if (bot && right) code = CT_BR;
      else if (bot)          code = CT_BOT;
      else if (left)         code = CT_LEFT;
      else if (right)        code = CT_RIGHT;
      return code;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// Fixed-length delay of DEPTH enabled shifts, built as a circular buffer with a
// single pointer: the oldest entry is read out and overwritten on each shift.
module line_buffer #(
   parameter int DEPTH      = 1,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic [DATA_WIDTH-1:0] dout_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         ptr_q, ptr_d;

   assign dout_o = mem[ptr_q];

   always_comb begin
      ptr_d = ptr_q;
      if (en_i) ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   always_ff @(posedge clk) begin
      if (en_i) mem[ptr_q] <= din_i;
   end

endmodule

// File: rtl/gauss_window_gen.sv
// Raster pixel stream in, one zero-padded 3x3 neighbourhood per pixel out, with
// the kernel-shape code for computing_block.
module gauss_window_gen
   import gauss_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] line0_data0,
   output logic [DATA_WIDTH-1:0] line0_data1,
   output logic [DATA_WIDTH-1:0] line0_data2,
   output logic [DATA_WIDTH-1:0] line1_data0,
   output logic [DATA_WIDTH-1:0] line1_data1,
   output logic [DATA_WIDTH-1:0] line1_data2,
   output logic [DATA_WIDTH-1:0] line2_data0,
   output logic [DATA_WIDTH-1:0] line2_data1,
   output logic [DATA_WIDTH-1:0] line2_data2,
   output logic [3:0]            corner_type,
   output logic                  out_eof
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   state_e state_q, state_d;
   logic [CW-1:0] in_col_q, in_col_d, ctr_col_q, ctr_col_d;
   logic [RW-1:0] in_row_q, in_row_d, ctr_row_q, ctr_row_d;

   // Tap order t = 3*line + data; dl holds delay-line indices
   // 0,1,2, W,W+1,W+2, 2W,2W+1,2W+2.
   logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] dl_q, dl_d, win, taps_q, taps_d;
   logic [3:0]            ct_q, ct_d;
   logic                  vld_q, vld_d, eof_q, eof_d;
   logic                  shift, emit, accept, adv;
   logic [DATA_WIDTH-1:0] din_sh, lb0_out, lb1_out;
   logic                  in_last, ctr_last, ctr_top, ctr_bot, ctr_left, ctr_right;

   line_buffer #(.DEPTH(IMG_WIDTH - 3), .DATA_WIDTH(DATA_WIDTH)) u_lb0 (
      .clk(clk), .rst_n(rst_n), .en_i(shift), .din_i(dl_q[2]), .dout_o(lb0_out));

   line_buffer #(.DEPTH(IMG_WIDTH - 3), .DATA_WIDTH(DATA_WIDTH)) u_lb1 (
      .clk(clk), .rst_n(rst_n), .en_i(shift), .din_i(dl_q[5]), .dout_o(lb1_out));

   assign in_last   = (in_row_q == RW'(IMG_HEIGHT - 1)) && (in_col_q == CW'(IMG_WIDTH - 1));
   assign ctr_top   = (ctr_row_q == '0);
   assign ctr_bot   = (ctr_row_q == RW'(IMG_HEIGHT - 1));
   assign ctr_left  = (ctr_col_q == '0);
   assign ctr_right = (ctr_col_q == CW'(IMG_WIDTH - 1));
   assign ctr_last  = ctr_bot && ctr_right;
   assign adv       = !vld_q || out_ready;

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      shift    = 1'b0;
      emit     = 1'b0;
      accept   = 1'b0;
      din_sh   = in_data;
      case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shift  = 1'b1;
               accept = 1'b1;
               // Pixel (1,0) is the (W+1)th of the frame.
               if (in_row_q == RW'(1) && in_col_q == '0) state_d = RUN;
            end
         end
         RUN: begin
            in_ready = adv;
            if (in_valid && adv) begin
               shift  = 1'b1;
               accept = 1'b1;
               emit   = 1'b1;
               if (in_last) state_d = FLUSH;
            end
         end
         FLUSH: begin
            din_sh = '0;
            if (adv) begin
               shift = 1'b1;
               emit  = 1'b1;
               if (ctr_last) state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      in_col_d  = in_col_q;
      in_row_d  = in_row_q;
      ctr_col_d = ctr_col_q;
      ctr_row_d = ctr_row_q;
      if (accept) begin
         if (in_col_q == CW'(IMG_WIDTH - 1)) begin
            in_col_d = '0;
            in_row_d = (in_row_q == RW'(IMG_HEIGHT - 1)) ? '0 : in_row_q + 1'b1;
         end else begin
            in_col_d = in_col_q + 1'b1;
         end
      end
      if (emit) begin
         if (ctr_right) begin
            ctr_col_d = '0;
            ctr_row_d = ctr_bot ? '0 : ctr_row_q + 1'b1;
         end else begin
            ctr_col_d = ctr_col_q + 1'b1;
         end
      end
   end

   // The emitted window is the post-shift delay line, so it is taken from dl_d.
   always_comb begin
      dl_d = dl_q;
      if (shift) begin
         dl_d[0] = din_sh;
         dl_d[1] = dl_q[0];
         dl_d[2] = dl_q[1];
         dl_d[3] = lb0_out;
         dl_d[4] = dl_q[3];
         dl_d[5] = dl_q[4];
         dl_d[6] = lb1_out;
         dl_d[7] = dl_q[6];
         dl_d[8] = dl_q[7];
      end
      for (int t = 0; t < NUM_TAPS; t++) begin
         win[t] = dl_d[t];
         if ((t / 3 == 0 && ctr_bot) || (t / 3 == 2 && ctr_top) ||
             (t % 3 == 0 && ctr_right) || (t % 3 == 2 && ctr_left))
            win[t] = '0;
      end
   end

   always_comb begin
      vld_d  = vld_q;
      taps_d = taps_q;
      ct_d   = ct_q;
      eof_d  = eof_q;
      if (emit) begin
         vld_d  = 1'b1;
         taps_d = win;
         ct_d   = corner_code(ctr_top, ctr_bot, ctr_left, ctr_right);
         eof_d  = ctr_last;
      end else if (out_ready) begin
         vld_d  = 1'b0;
         taps_d = '0;
         ct_d   = CT_NONE;
         eof_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FILL;
         in_col_q  <= '0;
         in_row_q  <= '0;
         ctr_col_q <= '0;
         ctr_row_q <= '0;
         dl_q      <= '0;
         taps_q    <= '0;
         ct_q      <= CT_NONE;
         vld_q     <= 1'b0;
         eof_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_col_q  <= in_col_d;
         in_row_q  <= in_row_d;
         ctr_col_q <= ctr_col_d;
         ctr_row_q <= ctr_row_d;
         dl_q      <= dl_d;
         taps_q    <= taps_d;
         ct_q      <= ct_d;
         vld_q     <= vld_d;
         eof_q     <= eof_d;
      end
   end

   assign out_valid   = vld_q;
   assign out_eof     = eof_q;
   assign corner_type = ct_q;
   assign line0_data0 = taps_q[0];
   assign line0_data1 = taps_q[1];
   assign line0_data2 = taps_q[2];
   assign line1_data0 = taps_q[3];
   assign line1_data1 = taps_q[4];
   assign line1_data2 = taps_q[5];
   assign line2_data0 = taps_q[6];
   assign line2_data1 = taps_q[7];
   assign line2_data2 = taps_q[8];

endmodule
